// File: rtl/serv_rf_ram_if_mp.sv
// Bit-serial multi-port register file front end for SERV, backed by one read and one write SRAM port.
// Requests latch their register addresses; x0 reads as zero and is never written.
module serv_rf_ram_if_mp #(
  parameter int width    = 8,
  parameter int W        = 1,
  parameter int csr_regs = 4,
  parameter int RPORTS   = 2,
  parameter int raw      = $clog2(32 + csr_regs),
  parameter int aw       = raw + 5 - $clog2(width)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rreq,
  input  logic                    i_wreq,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_err,
  input  logic [RPORTS*raw-1:0]   i_rreg,
  output logic [RPORTS*W-1:0]     o_rdata,
  input  logic [raw-1:0]          i_wreg0,
  input  logic [raw-1:0]          i_wreg1,
  input  logic                    i_wen0,
  input  logic                    i_wen1,
  input  logic [W-1:0]            i_wdata0,
  input  logic [W-1:0]            i_wdata1,
  output logic [aw-1:0]           o_raddr,
  output logic                    o_ren,
  input  logic [width-1:0]        i_rdata,
  output logic [aw-1:0]           o_waddr,
  output logic [width-1:0]        o_wdata,
  output logic                    o_wen
);

  localparam int RATIO = width / W;
  localparam int LR    = $clog2(RATIO);
  localparam int WW    = 5 - $clog2(width);
  localparam int NSL   = 32 / W;
  localparam int NWD   = 32 / width;
  localparam int CW    = $clog2(NSL + RPORTS + 3);

  localparam logic [CW-1:0] C_MASK     = CW'(RATIO - 1);
  localparam logic [CW-1:0] C_RD_LAST  = CW'(NSL + RPORTS + 1);
  localparam logic [CW-1:0] C_WR_LAST  = CW'(NSL + 2);
  localparam logic [CW-1:0] C_RD_START = CW'(RPORTS + 2);
  localparam logic [CW-1:0] C_READY    = CW'(RPORTS + 1);

  generate
    if (RATIO < 2 || RATIO < RPORTS) begin : g_bad_cfg
      $error("serv_rf_ram_if_mp: width/W must be >= max(2, RPORTS)");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            w_idle;
  logic            w_accept;
  logic            w_err_next;

  logic [raw-1:0]  r_rreg [RPORTS];
  logic [raw-1:0]  r_wreg0;
  logic [raw-1:0]  r_wreg1;
  logic            r_wen0;
  logic            r_wen1;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle & (i_rreq | i_wreq);
  // Colliding requests in IDLE and any request while busy are both rejections.
  assign w_err_next = w_idle ? (i_rreq & i_wreq) : (i_rreq | i_wreq);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_idle ? CW'(1) : r_cnt + CW'(1);
      r_err   <= w_err_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_wreq) w_state_next = S_WRITE;
               else if (i_rreq) w_state_next = S_READ;
      S_READ:  if (r_cnt == C_RD_LAST) w_state_next = S_IDLE;
      S_WRITE: if (r_cnt == C_WR_LAST) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wreg0 <= '0;
      r_wreg1 <= '0;
      r_wen0  <= 1'b0;
      r_wen1  <= 1'b0;
    end else if (w_accept) begin
      r_wreg0 <= i_wreg0;
      r_wreg1 <= i_wreg1;
      r_wen0  <= i_wen0;
      r_wen1  <= i_wen1;
    end
  end

  // Read fetch schedule: slot f = t-1 splits into word f/ratio and channel f%ratio.
  logic [CW-1:0]  w_f;
  logic [CW-1:0]  w_word;
  logic [CW-1:0]  w_p;
  logic           w_ren;
  logic [raw-1:0] w_rreg_sel;
  logic           r_rvalid;
  logic [CW-1:0]  r_rp;
  logic           w_rwin;
  logic [CW-1:0]  w_s;
  logic           w_bound;

  assign w_f     = r_cnt - CW'(1);
  assign w_word  = w_f >> LR;
  assign w_p     = w_f & C_MASK;
  assign w_ren   = (r_state == S_READ) && (w_p < CW'(RPORTS)) && (w_word < CW'(NWD));
  assign w_rwin  = (r_state == S_READ) && (r_cnt >= C_RD_START);
  assign w_s     = r_cnt - C_RD_START;
  assign w_bound = ((w_s & C_MASK) == '0);

  always_comb begin
    w_rreg_sel = '0;
    for (int i = 0; i < RPORTS; i++) begin
      if (w_p == CW'(i)) w_rreg_sel = r_rreg[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rp     <= '0;
    end else begin
      r_rvalid <= w_ren;
      r_rp     <= w_p;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RPORTS; gi++) begin : g_rch
      logic [width-1:0] r_stage;
      logic [width-1:0] r_shift;
      logic [W-1:0]     w_slice;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rreg[gi] <= '0;
          r_stage    <= '0;
          r_shift    <= '0;
        end else begin
          if (w_accept) r_rreg[gi] <= i_rreg[gi*raw +: raw];
          if (r_rvalid && r_rp == CW'(gi)) r_stage <= i_rdata;
          if (w_rwin) r_shift <= w_bound ? (r_stage >> W) : (r_shift >> W);
        end
      end

      // At a word boundary the first slice comes straight from staging.
      assign w_slice = w_bound ? r_stage[W-1:0] : r_shift[W-1:0];
      assign o_rdata[gi*W +: W] = (w_rwin && r_rreg[gi] != '0) ? w_slice : '0;
    end
  endgenerate

  // Write path: deserialise into shift registers, hand complete words to staging.
  logic [width-W-1:0] r_wsh0;
  logic [width-W-1:0] r_wsh1;
  logic [width-1:0]   w_wnew0;
  logic [width-1:0]   w_wnew1;
  logic [width-1:0]   r_wst0;
  logic [width-1:0]   r_wst1;
  logic               w_wsample;
  logic               w_wdone;
  logic [CW-1:0]      w_t1;
  logic [CW-1:0]      w_t2;
  logic               w_slot0;
  logic               w_slot1;
  logic [aw-1:0]      w_raddr;
  logic [aw-1:0]      w_waddr0;
  logic [aw-1:0]      w_waddr1;

  assign w_wnew0   = {i_wdata0, r_wsh0};
  assign w_wnew1   = {i_wdata1, r_wsh1};
  assign w_wsample = (r_state == S_WRITE) && (r_cnt <= CW'(NSL));
  assign w_wdone   = w_wsample && ((r_cnt & C_MASK) == '0);
  assign w_t1      = r_cnt - CW'(1);
  assign w_t2      = r_cnt - CW'(2);
  assign w_slot0   = (r_state == S_WRITE) && (r_cnt > CW'(RATIO)) && ((w_t1 & C_MASK) == '0);
  assign w_slot1   = (r_state == S_WRITE) && (r_cnt > CW'(RATIO + 1)) && ((w_t2 & C_MASK) == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wsh0 <= '0;
      r_wsh1 <= '0;
      r_wst0 <= '0;
      r_wst1 <= '0;
    end else begin
      if (w_wsample) begin
        r_wsh0 <= w_wnew0[width-1:W];
        r_wsh1 <= w_wnew1[width-1:W];
      end
      if (w_wdone) begin
        r_wst0 <= w_wnew0;
        r_wst1 <= w_wnew1;
      end
    end
  end

  generate
    if (WW > 0) begin : g_word
      logic [WW-1:0] w_k0;
      logic [WW-1:0] w_k1;
      assign w_k0     = WW'((w_t1 >> LR) - CW'(1));
      assign w_k1     = WW'((w_t2 >> LR) - CW'(1));
      assign w_raddr  = {w_rreg_sel, w_word[WW-1:0]};
      assign w_waddr0 = {r_wreg0, w_k0};
      assign w_waddr1 = {r_wreg1, w_k1};
    end else begin : g_noword
      assign w_raddr  = w_rreg_sel;
      assign w_waddr0 = r_wreg0;
      assign w_waddr1 = r_wreg1;
    end
  endgenerate

  // Output logic
  always_comb begin
    o_busy  = !w_idle;
    o_ready = (w_idle & i_wreq) | ((r_state == S_READ) && (r_cnt == C_READY));
    o_err   = r_err;
    o_ren   = w_ren;
    o_raddr = w_raddr;
    o_wen   = (w_slot0 & r_wen0 & (r_wreg0 != '0)) | (w_slot1 & r_wen1 & (r_wreg1 != '0));
    o_waddr = w_slot1 ? w_waddr1 : w_waddr0;
    o_wdata = w_slot1 ? r_wst1 : r_wst0;
  end

endmodule

// File: tb/tb_serv_rf_ram_if_mp.sv
// Directed bench for serv_rf_ram_if_mp (width=8, W=1, RPORTS=2) with an SRAM model and
// queue-based scoreboards for read words and RAM writes.
module tb_serv_rf_ram_if_mp;
  localparam int RAW = 6;
  localparam int AW  = 8;

  logic            clk = 1'b0;
  logic            i_rst_n, i_rreq, i_wreq;
  logic            o_ready, o_busy, o_err;
  logic [2*RAW-1:0] i_rreg;
  logic [1:0]      o_rdata;
  logic [RAW-1:0]  i_wreg0, i_wreg1;
  logic            i_wen0, i_wen1;
  logic [0:0]      i_wdata0, i_wdata1;
  logic [AW-1:0]   o_raddr, o_waddr;
  logic            o_ren, o_wen;
  logic [7:0]      i_rdata, o_wdata;

  logic [7:0]      mem  [256];
  logic [7:0]      gold [256];
  logic            load;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  serv_rf_ram_if_mp dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_rreq(i_rreq), .i_wreq(i_wreq),
    .o_ready(o_ready), .o_busy(o_busy), .o_err(o_err),
    .i_rreg(i_rreg), .o_rdata(o_rdata),
    .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen)
  );

  // SRAM model: registered read, data valid the cycle after o_ren
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= gold[i];
    end else begin
      if (o_ren) i_rdata <= mem[o_raddr];
      if (o_wen) mem[o_waddr] <= o_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gold_word(input logic [5:0] r);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = gold[{r, 2'(k)}];
    return v;
  endfunction

  task automatic set_word(input logic [5:0] r, input logic [31:0] v);
    for (int k = 0; k < 4; k++) gold[{r, 2'(k)}] = v[k*8 +: 8];
  endtask

  task automatic do_read(input logic [5:0] r0, input logic [5:0] r1, input int inj);
    logic [31:0] act0, act1, e;
    logic [5:0]  rr[2];
    logic [7:0]  ea;
    int          f;
    bit          er;
    rr[0] = r0;
    rr[1] = r1;
    act0 = '0;
    act1 = '0;
    rq.push_back((r0 == 6'd0) ? 32'd0 : gold_word(r0));
    rq.push_back((r1 == 6'd0) ? 32'd0 : gold_word(r1));
    @(posedge clk); #1;
    i_rreg = {r1, r0};
    i_rreq = 1'b1;
    for (int t = 0; t <= 36; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        i_rreq = (t == inj);
        i_rreg = 12'($urandom);
      end
      @(negedge clk);
      f  = t - 1;
      er = (t >= 1 && t <= 32 && (f % 8) < 2);
      check("rd_ren", o_ren, er);
      if (er) begin
        ea = {rr[f % 2], 2'(f / 8)};
        check("rd_raddr", o_raddr, ea);
      end
      check("rd_ready", o_ready, t == 3);
      check("rd_busy", o_busy, t >= 1 && t <= 35);
      check("rd_wen", o_wen, 1'b0);
      check("rd_err", o_err, inj >= 0 && t == inj + 1);
      if (t >= 4 && t <= 35) begin
        act0[t-4] = o_rdata[0];
        act1[t-4] = o_rdata[1];
      end else begin
        check("rd_idle_data", o_rdata, 2'b00);
      end
    end
    e = rq.pop_front();
    check("rd_ch0_word", act0, e);
    e = rq.pop_front();
    check("rd_ch1_word", act1, e);
    $display("read  rreg={%0d,%0d} ch0=%h ch1=%h", r1, r0, act0, act1);
  endtask

  task automatic do_write(input logic [5:0] w0, input logic e0, input logic [5:0] w1,
                          input logic e1, input logic [31:0] d0, input logic [31:0] d1,
                          input logic both, input int rst_at);
    wr_t x;
    bit  ew;
    int  lim;
    int  nw;
    lim = (rst_at >= 0) ? rst_at : 1000;
    nw  = 0;
    wq.delete();
    for (int k = 0; k < 4; k++) begin
      if (e0 && w0 != 6'd0 && (k + 1) * 8 + 1 < lim) begin
        x.addr = {w0, 2'(k)}; x.data = d0[k*8 +: 8]; x.cyc = (k + 1) * 8 + 1;
        wq.push_back(x); gold[x.addr] = x.data;
      end
      if (e1 && w1 != 6'd0 && (k + 1) * 8 + 2 < lim) begin
        x.addr = {w1, 2'(k)}; x.data = d1[k*8 +: 8]; x.cyc = (k + 1) * 8 + 2;
        wq.push_back(x); gold[x.addr] = x.data;
      end
    end
    @(posedge clk); #1;
    i_wreq = 1'b1; i_rreq = both;
    i_wreg0 = w0; i_wreg1 = w1; i_wen0 = e0; i_wen1 = e1;
    i_wdata0 = 1'($urandom); i_wdata1 = 1'($urandom);
    @(negedge clk);
    check("wr_grant", o_ready, 1'b1);
    check("wr_busy0", o_busy, 1'b0);
    check("wr_wen0", o_wen, 1'b0);
    for (int t = 1; t <= 36; t++) begin
      @(posedge clk); #1;
      i_wreq = 1'b0; i_rreq = 1'b0;
      i_wreg0 = 6'($urandom); i_wreg1 = 6'($urandom);
      i_wen0 = 1'($urandom); i_wen1 = 1'($urandom);
      if (t <= 32) begin
        i_wdata0 = d0[t-1];
        i_wdata1 = d1[t-1];
      end else begin
        i_wdata0 = 1'($urandom);
        i_wdata1 = 1'($urandom);
      end
      if (t == rst_at) i_rst_n = 1'b0;
      @(negedge clk);
      if (rst_at >= 0 && t >= rst_at) begin
        check("rst_outs", {o_ready, o_busy, o_err, o_ren, o_wen, o_rdata}, 7'd0);
      end else begin
        ew = (wq.size() > 0) && (wq[0].cyc == t);
        check("wr_wen", o_wen, ew);
        if (ew && o_wen) begin
          x = wq.pop_front();
          nw++;
          check("wr_waddr", o_waddr, x.addr);
          check("wr_wdata", o_wdata, x.data);
        end
        check("wr_busy", o_busy, t <= 34);
        check("wr_ren", o_ren, 1'b0);
        check("wr_ready", o_ready, 1'b0);
        check("wr_err", o_err, both && t == 1);
      end
    end
    check("wr_queue_drained", wq.size(), 0);
    $display("write wreg0=%0d wreg1=%0d d0=%h d1=%h writes=%0d", w0, w1, d0, d1, nw);
    if (rst_at >= 0) begin
      @(posedge clk); #1;
      i_rst_n = 1'b1;
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_rreq = 1'b0; i_wreq = 1'b0; i_rreg = '0;
    i_wreg0 = '0; i_wreg1 = '0; i_wen0 = 1'b0; i_wen1 = 1'b0;
    i_wdata0 = '0; i_wdata1 = '0; load = 1'b0;
    for (int i = 0; i < 256; i++) gold[i] = 8'($urandom);
    set_word(6'd5, 32'hDEADBEEF);
    set_word(6'd3, 32'h12345678);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    check("reset_outs", {o_ready, o_busy, o_err, o_ren, o_wen, o_rdata}, 7'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;

    do_read(6'd5, 6'd3, -1);
    do_read(6'd0, 6'd5, -1);
    do_write(6'd7, 1'b1, 6'd0, 1'b1, 32'hA5A5A5A5, $urandom, 1'b0, -1);
    do_read(6'd7, 6'd3, 10);
    do_write(6'd11, 1'b1, 6'd12, 1'b0, $urandom, $urandom, 1'b1, -1);
    do_read(6'd11, 6'd12, -1);
    do_write(6'd9, 1'b1, 6'd10, 1'b1, $urandom, $urandom, 1'b0, 12);
    do_read(6'd9, 6'd10, -1);
    do_write(6'd35, 1'b1, 6'd33, 1'b1, $urandom, $urandom, 1'b0, -1);
    do_read(6'd33, 6'd35, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serv_rf_ram_if_mp.md
Name: serv_rf_ram_if_mp

Overview:
- Multi-port, parametrised serialiser between SERV's bit-serial register file ports and a single-port-per-direction SRAM. It sits between the SERV core and the RF RAM.
- Generalises the fixed two-read-port interface: the read channel count is configurable via RPORTS.
- New behaviour over the previous block:
  - address and enables are latched at request time;
  - hard-wired x0 (reads return zero, writes are suppressed);
  - a busy flag;
  - an error pulse on illegal requests.

Parameters:
- width, 8: SRAM data width. Power of 2, 2..32.
- W, 1: serial bits per cycle per port (1, 2 or 4).
- csr_regs, 4: number of CSR registers, placed after the 32 GPRs.
- RPORTS, 2: number of read channels, 1..4.
- raw, $clog2(32+csr_regs): register address width. Derived, do not override.
- aw, raw+5-$clog2(width): RAM address width. Derived.
- Elaboration constraint: ratio = width/W must satisfy ratio >= max(2, RPORTS).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rreq  in  1  read transaction request (1-cycle pulse).
- i_wreq  in  1  write transaction request (1-cycle pulse).
- o_ready  out  1  read: 1-cycle pulse before the data stream starts; write: combinational grant in the request cycle.
- o_busy  out  1  a transaction is in progress.
- o_err  out  1  1-cycle pulse on a rejected request.
- i_rreg  in  RPORTS*raw  read register addresses; channel p occupies slice p.
- o_rdata  out  RPORTS*W  serial read data, LSB first.
- i_wreg0, i_wreg1  in  raw  write register addresses.
- i_wen0, i_wen1  in  1  write enables.
- i_wdata0, i_wdata1  in  W  serial write data, LSB first.
- o_raddr  out  aw  RAM read address.
- o_ren  out  1  RAM read strobe.
- i_rdata  in  width  RAM read data, valid the cycle after o_ren.
- o_waddr  out  aw  RAM write address.
- o_wdata  out  width  RAM write data.
- o_wen  out  1  RAM write strobe.

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE;
  - o_ready, o_busy, o_err, o_ren, o_wen = 0;
  - o_rdata = 0.
  - Reset mid-transaction aborts it; no further RAM strobes are issued.
- RAM address format: {reg, word}, where word = bit index / width (5-$clog2(width) bits). When width==32 the address is {reg} only.
- States: IDLE, READ, WRITE. "Cycle 0" is the request cycle; cycle t is t clocks later.
- Request acceptance (IDLE only):
  - i_wreq wins over i_rreq. If both are asserted, the write is accepted and o_err pulses in cycle 1.
  - A request while busy is ignored and o_err pulses in the next cycle.
  - i_rreg, i_wreg0/1 and i_wen0/1 are latched in cycle 0.
- READ:
  - Fetch slot f = t-1 for t >= 1, with word = f/ratio and channel p = f%ratio.
  - o_ren=1 with o_raddr = {rreg[p], word} iff p < RPORTS and word < 32/width.
  - Each returned word goes to the channel's staging register. The shift register loads from staging at word boundaries (double-buffered).
  - o_ready pulses in cycle RPORTS+1.
  - Slice j (W bits) of each channel is driven in cycle RPORTS+2+j, for j = 0..32/W-1.
  - A channel addressing register 0 outputs zeros.
  - o_rdata = 0 outside the stream window.
  - o_busy is high from cycle 1 through the last slice; state returns to IDLE the following cycle.
- WRITE:
  - o_ready = 1 combinationally in cycle 0.
  - Slice j of i_wdata0/1 is sampled in cycle j+1.
  - Word k completes at cycle (k+1)*ratio and moves to staging.
  - Port-0 write occurs at (k+1)*ratio+1 with o_waddr = {wreg0, k}.
  - Port-1 write occurs at (k+1)*ratio+2 with o_waddr = {wreg1, k}.
  - o_wen = wen_r & (wreg != 0) for the port being written.
  - o_busy stays high until the final port-1 slot, cycle 32/W+2, inclusive.
- Strobes:
  - o_ren and o_wen are never asserted in IDLE.
  - The read and write paths are independent; both strobes may be high in the same cycle only if both paths are active, which cannot happen because only one transaction runs at a time.
- Arithmetic:
  - Counters are sized to hold 32/W+RPORTS+2.
  - No wrap-around within a transaction; each counter resets on acceptance.

Test Plan:
1. width=8, W=1, RPORTS=2; RAM reg5=0xDEADBEEF, reg3=0x12345678; i_rreq with rreg={3,5} -> o_ren in cycles 1,2 (addr {5,0},{3,0}), 9,10, 17,18, 25,26; o_ready in cycle 3; ch0 streams 0xDEADBEEF LSB-first in cycles 4..35 and ch1 streams 0x12345678; o_busy low at 36.
2. Same configuration, read with rreg={0,5} -> ch0 outputs all zeros and ch1 outputs 0xDEADBEEF.
3. i_wreq with wreg0=7, wen0=1, wreg1=0, wen1=1, wdata0=0xA5A5A5A5 -> o_ready in cycle 0; o_wen in cycles 9,17,25,33 with addr {7,0..3} and o_wdata=0xA5; no o_wen in cycles 10,18,26,34; o_busy low at 35.
4. i_rreq while a read is active (cycle 10) -> o_err pulse in cycle 11; the original stream is undisturbed.
5. i_rreq and i_wreq together in IDLE -> write accepted, o_err in cycle 1, no o_ren.
6. i_rst_n low in cycle 12 of a write -> all outputs 0 immediately, no o_wen after reset, and a new i_rreq is accepted after release.
